// File: rtl/wide_add_seq_pkg.sv
// Shared types and sizing helpers for the wide_add_seq slice-serial adder.
// Optional overflow flag output is enabled by defining WIDE_ADD_SEQ_OVF_EN.
package wide_add_seq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Width of the slice counter; kept at least 1 bit so a lone slice still elaborates.
   function automatic int cnt_width(input int ns);
      return (ns > 1) ? $clog2(ns) : 1;
   endfunction

endpackage

// File: rtl/wide_add_seq_a1csa16bits.sv
// 16-bit add-one carry-select adder: each 4-bit group forms a+b and a+b+1,
// and the incoming group carry picks one of them.
module a1csa16bits (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);

   localparam int GRP_W = 4;
   localparam int NGRP  = 16 / GRP_W;

   always_comb begin
      logic             c;
      logic [GRP_W:0]   sum0;
      logic [GRP_W-1:0] sum1;
      logic             c1;
      // NOTE: every variable gets a value before any branch reads it, so no latch is inferred.
      c    = cin;
      sum0 = '0;
      sum1 = '0;
      c1   = 1'b0;
      s    = '0;
      for (int g = 0; g < NGRP; g++) begin
         sum0 = {1'b0, a[g*GRP_W +: GRP_W]} + {1'b0, b[g*GRP_W +: GRP_W]};
         sum1 = sum0[GRP_W-1:0] + GRP_W'(1);
         c1   = sum0[GRP_W] | (&sum0[GRP_W-1:0]);
         s[g*GRP_W +: GRP_W] = c ? sum1 : sum0[GRP_W-1:0];
         c    = c ? c1 : sum0[GRP_W];
      end
      cout = c;
   end

endmodule

// File: rtl/wide_add_seq.sv
// W-bit adder that streams operands through one 16-bit slice adder, LSB slice first.
// Define WIDE_ADD_SEQ_OVF_EN to add the two's-complement overflow output ovf.
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         cout
`ifdef WIDE_ADD_SEQ_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int NS    = W / SLICE_W;
   localparam int CNT_W = cnt_width(NS);

   if (((W % SLICE_W) != 0) || (W < 2 * SLICE_W)) begin : g_bad_width
      $error("wide_add_seq: W must be a multiple of 16 and at least 32");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               c_q, c_d;
   logic [W-1:0]       a_h_q, a_h_d;
   logic [W-1:0]       b_h_q, b_h_d;
   logic [W-1:0]       s_q, s_d;
   logic               cout_q, cout_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
   logic               slice_cout;
   logic               last_slice;

   assign slice_a    = a_h_q[cnt_q*SLICE_W +: SLICE_W];
   assign slice_b    = b_h_q[cnt_q*SLICE_W +: SLICE_W];
   assign last_slice = (cnt_q == CNT_W'(NS - 1));

   a1csa16bits u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (c_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      c_d         = c_q;
      a_h_d       = a_h_q;
      b_h_d       = b_h_q;
      s_d         = s_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_h_d      = a;
               b_h_d      = b;
               c_d        = cin;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            s_d[cnt_q*SLICE_W +: SLICE_W] = slice_s;
            c_d   = slice_cout;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_slice) begin
               cout_d      = slice_cout;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef WIDE_ADD_SEQ_OVF_EN
               ovf_d = (a_h_q[W-1] == b_h_q[W-1]) && (slice_s[SLICE_W-1] != a_h_q[W-1]);
`endif
            end
         end
         DONE: begin
            // in_ready only rises once IDLE is reached, so handoff and accept never share a cycle.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         c_q         <= 1'b0;
         a_h_q       <= '0;
         b_h_q       <= '0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         c_q         <= c_d;
         a_h_q       <= a_h_d;
         b_h_q       <= b_h_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef WIDE_ADD_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: queue-based arithmetic model plus directed literal cases.
// Exercises the ovf output as well when WIDE_ADD_SEQ_OVF_EN is defined.
module tb_wide_add_seq;

   localparam int W  = 64;
   localparam int NS = W / 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         cin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] s;
   logic         cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   wide_add_seq #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
`ifdef WIDE_ADD_SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   typedef struct {
      logic [W:0] sum;
      logic       ovf;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_acc  = -1;
   int   last_hand = -1;
   bit   op2_done  = 1'b0;
   bit   stop_rand = 1'b0;

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic tc, input int acc);
      exp_t e;
      e.sum = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
      e.ovf = (ta[W-1] == tb_[W-1]) && (e.sum[W-1] != ta[W-1]);
      e.acc = acc;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      for (int k = 0; k < NS; k++) begin
         case ($urandom_range(0, 3))
            0:       v[k*16 +: 16] = 16'hFFFF;
            1:       v[k*16 +: 16] = 16'h0000;
            default: v[k*16 +: 16] = 16'($urandom);
         endcase
      end
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: model derived purely from handshake timing and a+b+cin.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         bit ov_exp;
         ov_exp = 1'b0;
         if (q.size() > 0) ov_exp = (cyc >= q[0].acc + NS + 1);
         check("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, (q.size() == 0)});
         check("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, ov_exp});
         if (out_valid && q.size() > 0) begin
            check("s", {1'b0, s}, {1'b0, q[0].sum[W-1:0]});
            check("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, q[0].sum[W]});
`ifdef WIDE_ADD_SEQ_OVF_EN
            check("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, q[0].ovf});
`endif
            if (out_ready) begin
               void'(q.pop_front());
               last_hand = cyc;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, cyc));
            last_acc = cyc;
         end
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
      int n;
      n = 0;
      @(posedge clk);
      #1;
      a = ta;
      b = tb_;
      cin = tc;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            timeout_fail("accept_timeout");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_out(output int vcyc);
      int n;
      n = 0;
      vcyc = -1;
      while (n < 100) begin
         @(negedge clk);
         if (out_valid) begin
            vcyc = cyc;
            break;
         end
         n++;
      end
      if (vcyc < 0) timeout_fail("out_timeout");
   endtask

   task automatic run_directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                               input logic tc, input logic [W-1:0] s_exp, input logic cout_exp,
                               input logic ovf_exp);
      int vc;
      send(ta, tb_, tc);
      wait_out(vc);
      check({name, "_s"}, {1'b0, s}, {1'b0, s_exp});
      check({name, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, cout_exp});
`ifdef WIDE_ADD_SEQ_OVF_EN
      check({name, "_ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, ovf_exp});
`else
      if (ovf_exp === 1'bx) $display("unexpected x flag");
`endif
   endtask

   initial begin
      int vc;
      logic [W-1:0] s_hold;
      logic         c_hold;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
      check("rst_s", {1'b0, s}, '0);
      check("rst_cout", {{W{1'b0}}, cout}, '0);
`ifdef WIDE_ADD_SEQ_OVF_EN
      check("rst_ovf", {{W{1'b0}}, ovf}, '0);
`endif

      out_ready = 1'b1;
      send(64'h1, 64'h2, 1'b0);
      wait_out(vc);
      check("t1_latency", (W+1)'(vc - last_acc), (W+1)'(NS + 1));
      check("t1_s", {1'b0, s}, (W+1)'(64'h3));
      check("t1_cout", {{W{1'b0}}, cout}, '0);

      run_directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
      run_directed("interslice", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                   64'h0001_0000_0001_0000, 1'b0, 1'b0);
      run_directed("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run_directed("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                   64'h0, 1'b1, 1'b1);

      // Back-pressure with a second operand pair pending.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      op2_done = 1'b0;
      fork
         begin
            send(64'hDEAD_BEEF_0000_0001, 64'h2, 1'b0);
            op2_done = 1'b1;
         end
      join_none
      wait_out(vc);
      s_hold = s;
      c_hold = cout;
      check("bp_s", {1'b0, s}, (W+1)'(64'h2222_2222_2222_2212));
      repeat (10) begin
         @(negedge clk);
         check("bp_s_stable", {1'b0, s}, {1'b0, s_hold});
         check("bp_cout_stable", {{W{1'b0}}, cout}, {{W{1'b0}}, c_hold});
         check("bp_in_ready", {{W{1'b0}}, in_ready}, '0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      for (int n = 0; n < 20 && !op2_done; n++) @(posedge clk);
      if (!op2_done) timeout_fail("bp_second_accept");
      check("bp_accept_next", (W+1)'(last_acc), (W+1)'(last_hand + 1));
      out_ready = 1'b1;
      wait_out(vc);
      check("bp_second_s", {1'b0, s}, (W+1)'(64'hDEAD_BEEF_0000_0003));

      // Reset on the second RUN cycle discards the operation.
      @(posedge clk);
      send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      check("mid_rst_out_valid", {{W{1'b0}}, out_valid}, '0);
      check("mid_rst_s", {1'b0, s}, '0);
      run_directed("post_rst", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b1,
                   64'h0000_0000_0000_0001, 1'b1, 1'b0);

      // Randomized operands with random back-pressure.
      stop_rand = 1'b0;
      fork
         begin
            while (!stop_rand) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 200; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      stop_rand = 1'b1;
      @(posedge clk);
      #2 out_ready = 1'b1;
      for (int n = 0; n < 50 && q.size() > 0; n++) @(posedge clk);
      @(negedge clk);
      check("drain", (W+1)'(q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle W-bit adder sequencer that sits directly upstream of the team's 16-bit add-one carry-select adder (a1csa16bits).
- Accepts W-bit operand pairs over a valid/ready handshake.
- Feeds them to one a1csa16bits instance, 16 bits per cycle, LSB slice first; the slice carry is registered between cycles.
- Returns the W-bit sum and carry-out over a valid/ready handshake.
- Trades latency for area versus a flat W-bit adder.

Parameters:
- W, 64, operand/sum width; must be a multiple of 16 and at least 32 (elaboration error otherwise).
- NS, W/16, slice count (derived; not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in for slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  W  sum
- cout  output  1  carry-out of top slice

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, slice counter=0, carry register=0.
- States:
  - IDLE: in_ready=1. When in_valid && in_ready, capture a, b and cin into holding registers, set counter=0, go to RUN.
  - RUN: in_ready=0. Each cycle, the adder slice sees a_h[16k+15:16k], b_h[16k+15:16k] and carry register c (c=cin on k=0). Write the slice sum into s[16k+15:16k] and latch the slice cout into c. Increment k. On k=NS-1, also drive cout from the slice carry-out and go to DONE.
  - DONE: out_valid=1, in_ready=0. s and cout are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Latency: accept edge to out_valid high is NS+1 cycles (W=64: 5). Throughput is one operation per NS+2 cycles when out_ready is held high.
- No accept in the same cycle as result handoff: in_ready rises the cycle after DONE exits.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(W+1); unsigned; no saturation.
- s is written slice by slice during RUN. The consumer may only sample s when out_valid=1.
- Operands and cin are sampled only at the accept edge. Changes on a, b and cin while in RUN or DONE are ignored.
- Reset mid-RUN or mid-DONE: return to IDLE on the next edge and discard the result. out_valid=0 and s=0 in the cycle after rst.
- in_valid held while busy: the operands stay pending. They are accepted on the first IDLE cycle.
- out_ready asserted outside DONE: ignored.

Optional Feature:
- Macro: WIDE_ADD_SEQ_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), the two's-complement overflow flag.
  - ovf = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]), computed from the held operands and the final slice.
  - Valid with out_valid; reset value 0; held in DONE.
- When undefined:
  - Port absent; no extra logic.

Decomposition:
- Package wide_add_seq_pkg:
  - SLICE_W=16.
  - State enum {IDLE, RUN, DONE}, encoded 2'b00, 2'b01, 2'b10.
  - Function computing counter width $clog2(NS).
- One sub-module: instantiate the existing a1csa16bits as the slice adder, with .cin=c, .a/.b = selected slices, and .s/.cout feeding the registers.
- The slice mux is driven by the counter. No second adder instance.

Test Plan:
- W=64, a=64'h0000_0000_0000_0001, b=64'h0000_0000_0000_0002, cin=0, out_ready=1 -> out_valid high 5 cycles after accept; s=64'h3, cout=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, cout=1 (full carry ripple across all 4 slices).
- a=64'h0000_FFFF_0000_FFFF, b=64'h0000_0001_0000_0001, cin=0 -> s=64'h0001_0000_0001_0000, cout=0 (inter-slice carry at slices 0→1 and 2→3).
- Result back-pressure: out_ready=0 for 10 cycles in DONE, with a second in_valid pending -> s and cout stable and in_ready=0 throughout. After out_ready=1 for one cycle, the second operand pair is accepted on the next cycle.
- rst asserted on 2nd RUN cycle -> next cycle state IDLE, out_valid=0, s=0, in_ready=1. A new operation after reset gives the correct sum.
- WIDE_ADD_SEQ_OVF_EN defined: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> s=64'h8000_0000_0000_0000, ovf=1, cout=0. a=64'h8000_0000_0000_0000, b=64'h8000_0000_0000_0000 -> s=0, ovf=1, cout=1.
